// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_INC    = 32'd4;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/ready port used by the fetch stage.
interface fetch_if;

    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic [31:0] ImemRdata;

    modport master (
        output ImemReq,
        output ImemAddr,
        input  ImemReady,
        input  ImemRdata
    );

    modport slave (
        input  ImemReq,
        input  ImemAddr,
        output ImemReady,
        output ImemRdata
    );

endinterface

// File: rtl/fetch_hold_buffer.sv
// Holds the instruction returned while decode is stalled.
module fetch_hold_buffer
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] data,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            q <= NOP_INSTR;
        end else if (load) begin
            q <= data;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC owner and instruction fetch FSM with wait-state tolerant memory port.
// Optional FETCH_PERF_CNT_EN adds saturating bubble/redirect counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PERF_W   = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        RedirectE,
    input  logic [31:0] RedirectPCE,
    fetch_if.master     imem,
    output logic [31:0] InstrF,
    output logic [31:0] PCPlus4F,
    output logic        FetchBubbleF
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] BubbleCnt,
    output logic [PERF_W-1:0] RedirectCnt
`endif
);

    if (PERF_W < 1) begin : g_perf_w_chk
        $error("PERF_W must be positive");
    end

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  drain_addr, drain_n;
    logic [31:0]  hold_instr;
    logic         hold_load, hold_clear;

    fetch_hold_buffer u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (hold_load),
        .clear (hold_clear),
        .data  (imem.ImemRdata),
        .q     (hold_instr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        drain_n       = drain_addr;
        hold_load     = 1'b0;
        hold_clear    = 1'b0;
        imem.ImemReq  = 1'b0;
        imem.ImemAddr = pc;
        InstrF        = NOP_INSTR;
        FetchBubbleF  = 1'b1;
        PCPlus4F      = pc_next(pc);

        unique case (state)
            FETCH: begin
                imem.ImemReq = 1'b1;
                if (RedirectE) begin
                    pc_n = RedirectPCE;
                    // An in-flight request cannot be aborted; retire it in DRAIN.
                    if (!imem.ImemReady) begin
                        drain_n = pc;
                        state_n = DRAIN;
                    end
                end else if (imem.ImemReady) begin
                    InstrF       = imem.ImemRdata;
                    FetchBubbleF = 1'b0;
                    if (StallF) begin
                        hold_load = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        pc_n = pc_next(pc);
                    end
                end
            end
            HOLD: begin
                if (RedirectE) begin
                    hold_clear = 1'b1;
                    pc_n       = RedirectPCE;
                    state_n    = FETCH;
                end else begin
                    InstrF       = hold_instr;
                    FetchBubbleF = 1'b0;
                    if (!StallF) begin
                        pc_n    = pc_next(pc);
                        state_n = FETCH;
                    end
                end
            end
            DRAIN: begin
                imem.ImemReq  = 1'b1;
                imem.ImemAddr = drain_addr;
                if (RedirectE) begin
                    pc_n = RedirectPCE;
                end
                if (imem.ImemReady) begin
                    state_n = FETCH;
                end
            end
            default: begin
                state_n = FETCH;
            end
        endcase

        if (reset) begin
            imem.ImemReq = 1'b0;
            InstrF       = NOP_INSTR;
            PCPlus4F     = '0;
            FetchBubbleF = 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            BubbleCnt   <= '0;
            RedirectCnt <= '0;
        end else begin
            if (FetchBubbleF && !(&BubbleCnt)) begin
                BubbleCnt <= BubbleCnt + PERF_W'(1);
            end
            if (RedirectE && !(&RedirectCnt)) begin
                RedirectCnt <= RedirectCnt + PERF_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: per-cycle expected outputs are queued.
module tb_fetch_stage;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a << 4) ^ 32'hA5C3_0013;
    endfunction

    typedef struct {
        bit          sel;
        bit          req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] p4;
        bit          bub;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rdy0 = 1'b0, stl0 = 1'b0, red0 = 1'b0;
    logic        rst1 = 1'b1, rdy1 = 1'b0, stl1 = 1'b0, red1 = 1'b0;
    logic [31:0] tgt0 = '0, tgt1 = '0;
    logic [31:0] instr0, p4_0, instr1, p4_1;
    logic        bub0, bub1;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bcnt0, rcnt0, bcnt1, rcnt1;
`endif

    fetch_if if0 ();
    fetch_if if1 ();

    assign if0.ImemReady = rdy0;
    assign if0.ImemRdata = word_at(if0.ImemAddr);
    assign if1.ImemReady = rdy1;
    assign if1.ImemRdata = word_at(if1.ImemAddr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut0 (
        .clk          (clk),
        .reset        (rst0),
        .StallF       (stl0),
        .RedirectE    (red0),
        .RedirectPCE  (tgt0),
        .imem         (if0.master),
        .InstrF       (instr0),
        .PCPlus4F     (p4_0),
        .FetchBubbleF (bub0)
`ifdef FETCH_PERF_CNT_EN
        ,
        .BubbleCnt    (bcnt0),
        .RedirectCnt  (rcnt0)
`endif
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk          (clk),
        .reset        (rst1),
        .StallF       (stl1),
        .RedirectE    (red1),
        .RedirectPCE  (tgt1),
        .imem         (if1.master),
        .InstrF       (instr1),
        .PCPlus4F     (p4_1),
        .FetchBubbleF (bub1)
`ifdef FETCH_PERF_CNT_EN
        ,
        .BubbleCnt    (bcnt1),
        .RedirectCnt  (rcnt1)
`endif
    );

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!e.sel) begin
                chk("req0", {31'b0, if0.ImemReq}, {31'b0, e.req});
                if (e.req) chk("addr0", if0.ImemAddr, e.addr);
                chk("instr0", instr0, e.instr);
                chk("p4_0", p4_0, e.p4);
                chk("bub0", {31'b0, bub0}, {31'b0, e.bub});
            end else begin
                chk("req1", {31'b0, if1.ImemReq}, {31'b0, e.req});
                if (e.req) chk("addr1", if1.ImemAddr, e.addr);
                chk("instr1", instr1, e.instr);
                chk("p4_1", p4_1, e.p4);
                chk("bub1", {31'b0, bub1}, {31'b0, e.bub});
            end
        end
    end

    task automatic step(input bit s, input bit r, input bit rdy,
                        input bit stl, input bit red,
                        input logic [31:0] tgt, input bit e_req,
                        input logic [31:0] e_addr, input logic [31:0] e_instr,
                        input logic [31:0] e_p4, input bit e_bub);
        exp_t e;
        @(posedge clk);
        #1;
        if (!s) begin
            rst0 = r; rdy0 = rdy; stl0 = stl; red0 = red; tgt0 = tgt;
            rst1 = 1'b1;
        end else begin
            rst1 = r; rdy1 = rdy; stl1 = stl; red1 = red; tgt1 = tgt;
            rst0 = 1'b1;
        end
        e.sel = s; e.req = e_req; e.addr = e_addr;
        e.instr = e_instr; e.p4 = e_p4; e.bub = e_bub;
        sb.push_back(e);
    endtask

    task automatic rst_c(input bit s);
        step(s, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic go(input bit s, input bit rdy, input bit stl, input bit red,
                      input logic [31:0] tgt, input bit e_req,
                      input logic [31:0] e_addr, input logic [31:0] e_instr,
                      input logic [31:0] e_p4, input bit e_bub);
        step(s, 1'b0, rdy, stl, red, tgt, e_req, e_addr, e_instr, e_p4, e_bub);
    endtask

    initial begin
        logic [31:0] a;
        // zero-wait streaming from reset
        rst_c(0);
        rst_c(0);
        for (int i = 0; i < 4; i++) begin
            a = 32'(4 * i);
            go(0, 1, 0, 0, 0, 1, a, word_at(a), a + 4, 0);
        end
        // three wait cycles at PC=8
        rst_c(0);
        go(0, 1, 0, 0, 0, 1, 0, word_at(0), 4, 0);
        go(0, 1, 0, 0, 0, 1, 4, word_at(4), 8, 0);
        repeat (3) go(0, 0, 0, 0, 0, 1, 8, 0, 12, 1);
        go(0, 1, 0, 0, 0, 1, 8, word_at(8), 12, 0);
        go(0, 1, 0, 0, 0, 1, 12, word_at(12), 16, 0);
        // stall holds word@4 for three cycles
        rst_c(0);
        go(0, 1, 0, 0, 0, 1, 0, word_at(0), 4, 0);
        go(0, 1, 1, 0, 0, 1, 4, word_at(4), 8, 0);
        go(0, 0, 1, 0, 0, 0, 0, word_at(4), 8, 0);
        go(0, 0, 0, 0, 0, 0, 0, word_at(4), 8, 0);
        go(0, 1, 0, 0, 0, 1, 8, word_at(8), 12, 0);
        // redirect while waiting, then re-redirect during drain
        rst_c(0);
        go(0, 1, 0, 0, 0, 1, 0, word_at(0), 4, 0);
        go(0, 1, 0, 0, 0, 1, 4, word_at(4), 8, 0);
        go(0, 1, 0, 0, 0, 1, 8, word_at(8), 12, 0);
        go(0, 0, 0, 1, 32'h100, 1, 12, 0, 16, 1);
        go(0, 0, 0, 0, 0, 1, 12, 0, 32'h104, 1);
        go(0, 0, 0, 1, 32'h200, 1, 12, 0, 32'h104, 1);
        go(0, 1, 0, 0, 0, 1, 12, 0, 32'h204, 1);
        go(0, 1, 0, 0, 0, 1, 32'h200, word_at(32'h200), 32'h204, 0);
        // redirect on a completing fetch discards the data
        go(0, 1, 0, 1, 32'h40, 1, 32'h204, 0, 32'h208, 1);
        // redirect beats stall in HOLD
        go(0, 1, 1, 0, 0, 1, 32'h40, word_at(32'h40), 32'h44, 0);
        go(0, 0, 1, 1, 32'h80, 0, 0, 0, 32'h44, 1);
        go(0, 1, 0, 0, 0, 1, 32'h80, word_at(32'h80), 32'h84, 0);
        // reset during a wait
        go(0, 0, 0, 0, 0, 1, 32'h84, 0, 32'h88, 1);
        rst_c(0);
        go(0, 1, 0, 0, 0, 1, 0, word_at(0), 4, 0);
        // wrap-around from RESET_PC=FFFF_FFFC
        rst_c(1);
        rst_c(1);
        go(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC), 0, 0);
        go(1, 1, 0, 0, 0, 1, 0, word_at(0), 4, 0);
        go(1, 0, 0, 0, 0, 1, 4, 0, 8, 1);
        rst_c(1);
        go(1, 1, 0, 0, 0, 1, 32'hFFFF_FFFC, word_at(32'hFFFF_FFFC), 0, 0);
        @(negedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch-side producer for the Fetch/Decode pipe register; generates InstrF and PCPlus4F each cycle.
- Owns the PC register and drives a request/ready instruction-memory port that tolerates wait states.
- Honours StallF from the hazard unit and accepts Execute-stage branch redirects.
- Raises FetchBubbleF when no valid instruction is available; the hazard unit ORs this into FlushD.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PERF_W, 32, width of the performance counters (used only with FETCH_PERF_CNT_EN).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- StallF  input  1  hazard-unit stall; hold the current instruction and PC.
- RedirectE  input  1  taken branch / PC write resolved in Execute.
- RedirectPCE  input  32  redirect target; word-aligned.
- ImemReq  output  1  instruction-memory request valid.
- ImemAddr  output  32  request address; stable while ImemReq=1 and ImemReady=0.
- ImemReady  input  1  request completes this cycle; ImemRdata valid.
- ImemRdata  input  32  instruction word.
- InstrF  output  32  fetched instruction; 0 (NOP) when bubbling.
- PCPlus4F  output  32  PC of InstrF + 4.
- FetchBubbleF  output  1  InstrF is not valid; decode must see a bubble.

Behaviour:
- Registers:
  - PC, the current fetch address.
  - DrainAddr, the address of an abandoned outstanding request.
  - HoldInstr, the captured instruction.
  - state, one of FETCH, HOLD, DRAIN.
- Reset, while reset is high:
  - state=FETCH, PC=RESET_PC, HoldInstr=0, DrainAddr=0.
  - Outputs forced to ImemReq=0, InstrF=0, PCPlus4F=0, FetchBubbleF=1.
  - Reset mid-transaction abandons it; memory must tolerate ImemReq deasserting.
- Memory protocol:
  - Once ImemReq=1 with ImemReady=0, ImemReq and ImemAddr hold until ImemReady=1.
  - Requests are never aborted.
  - ImemRdata is sampled combinationally in the ImemReady cycle.
- PCPlus4F = PC+4 in every non-reset cycle. Arithmetic is 32-bit with wrap-around (32'hFFFF_FFFC+4 = 0).
- FETCH state:
  - Drives ImemReq=1, ImemAddr=PC.
  - ImemReady=0: InstrF=0, FetchBubbleF=1, stay in FETCH (StallF is irrelevant).
  - ImemReady=1, no redirect, !StallF: InstrF=ImemRdata, FetchBubbleF=0, PC<=PC+4.
  - ImemReady=1, no redirect, StallF: InstrF=ImemRdata, FetchBubbleF=0, HoldInstr<=ImemRdata, go to HOLD.
- HOLD state:
  - Drives ImemReq=0, InstrF=HoldInstr, FetchBubbleF=0.
  - When !StallF: PC<=PC+4, go to FETCH.
- DRAIN state:
  - Drives ImemReq=1, ImemAddr=DrainAddr, InstrF=0, FetchBubbleF=1.
  - When ImemReady=1: discard the data, go to FETCH with the already-updated PC.
- Redirect (RedirectE=1) has priority over StallF in every state:
  - FETCH with ImemReady=1: data discarded, InstrF=0, FetchBubbleF=1, PC<=RedirectPCE, stay in FETCH.
  - FETCH with ImemReady=0: DrainAddr<=PC, PC<=RedirectPCE, go to DRAIN.
  - HOLD: HoldInstr dropped, InstrF=0, FetchBubbleF=1, PC<=RedirectPCE, go to FETCH.
  - DRAIN: PC<=RedirectPCE (last redirect wins); if ImemReady=1 go to FETCH, else stay in DRAIN.
- Redirect at reset: reset wins.
- Latency: zero-wait memory gives one instruction per cycle with no bubbles; each memory wait cycle adds exactly one bubble.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs BubbleCnt[PERF_W] (cycles with FetchBubbleF=1 and reset=0) and RedirectCnt[PERF_W] (cycles with RedirectE=1 and reset=0).
  - Both counters clear on reset and saturate at all-ones.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum logic [1:0] fetch_state_t {FETCH, HOLD, DRAIN}.
  - NOP_INSTR=32'h0.
  - PC_INC=32'd4.
- Sub-module fetch_hold_buffer: the 32-bit HoldInstr register with load/clear, keeping HOLD-path data separate from the FSM.

Test Plan:
- Reset then zero-wait memory (ImemReady=1), ImemRdata=addr-derived pattern:
  - PCs requested are 0,4,8,12.
  - FetchBubbleF=0 every cycle; PCPlus4F=4,8,12,16.
- ImemReady low for 3 cycles at PC=8:
  - ImemAddr stays 8 and ImemReq stays 1.
  - 3 bubbles with InstrF=0, then InstrF=word@8, PCPlus4F=12.
- StallF high for 2 cycles after word@4 is returned:
  - InstrF=word@4 for 3 cycles; ImemReq=0 during HOLD.
  - PC advances to 8 only after StallF falls.
- RedirectE with RedirectPCE=32'h100 while waiting at PC=12:
  - DRAIN keeps ImemAddr=12 until ready; those data are discarded with a bubble.
  - Next request address is 32'h100.
- RedirectE and StallF together in HOLD:
  - Redirect wins: FetchBubbleF=1, next ImemAddr=target.
- RESET_PC=32'hFFFF_FFFC:
  - First PCPlus4F=0, second request address is 0.
  - Reset asserted mid-wait gives ImemReq=0 next cycle and a restart at RESET_PC.
